// File: rtl/qc_pkg.sv
// Shared types and constants for the gate engine datapath and control.
package qc_pkg;

  localparam int FRAC_DEFAULT = 14;
  localparam int H_COEFF      = 11585;

  typedef enum logic [1:0] {
    OP_X = 2'd0,
    OP_Z = 2'd1,
    OP_H = 2'd2,
    OP_S = 2'd3
  } gate_op_t;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR_A,
    WR_B,
    FIN
  } state_t;

  // One spare bit so out-of-range targets can be presented and flagged.
  function automatic int targetWidth(input int nQubits);
    return $clog2(nQubits) + 1;
  endfunction

endpackage

// File: rtl/gate_engine_if.sv
// Gate request handshake plus the state-memory bus between engine and memory.
interface gate_engine_if
  import qc_pkg::*;
#(
  parameter int N_QUBITS = 4,
  parameter int WIDTH    = 16
);

  localparam int TW = targetWidth(N_QUBITS);

  logic                       gate_valid;
  logic                       gate_ready;
  gate_op_t                   gate_op;
  logic        [TW-1:0]       gate_target;

  logic                       mem_we;
  logic        [N_QUBITS-1:0] mem_addr_a;
  logic        [N_QUBITS-1:0] mem_addr_b;
  logic signed [WIDTH-1:0]    mem_din_r;
  logic signed [WIDTH-1:0]    mem_din_i;
  logic signed [WIDTH-1:0]    mem_dout_a_r;
  logic signed [WIDTH-1:0]    mem_dout_a_i;
  logic signed [WIDTH-1:0]    mem_dout_b_r;
  logic signed [WIDTH-1:0]    mem_dout_b_i;

  modport slave (
    input  gate_valid, gate_op, gate_target,
    input  mem_dout_a_r, mem_dout_a_i, mem_dout_b_r, mem_dout_b_i,
    output gate_ready,
    output mem_we, mem_addr_a, mem_addr_b, mem_din_r, mem_din_i
  );

  modport master (
    output gate_valid, gate_op, gate_target,
    output mem_dout_a_r, mem_dout_a_i, mem_dout_b_r, mem_dout_b_i,
    input  gate_ready,
    input  mem_we, mem_addr_a, mem_addr_b, mem_din_r, mem_din_i
  );

endinterface

// File: rtl/cplx_butterfly.sv
// Combinational single-qubit gate on one amplitude pair (a, b) with
// rounding and saturation to the WIDTH-bit signed range.
module cplx_butterfly
  import qc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRAC  = FRAC_DEFAULT
) (
  input  logic signed [WIDTH-1:0] aR_i,
  input  logic signed [WIDTH-1:0] aI_i,
  input  logic signed [WIDTH-1:0] bR_i,
  input  logic signed [WIDTH-1:0] bI_i,
  input  gate_op_t                op_i,
  output logic signed [WIDTH-1:0] aR_o,
  output logic signed [WIDTH-1:0] aI_o,
  output logic signed [WIDTH-1:0] bR_o,
  output logic signed [WIDTH-1:0] bI_o
);

  localparam int PW = 2 * WIDTH + 1;

  localparam logic signed [WIDTH-1:0] MAX_V   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MIN_V   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [PW-1:0]    MAX_P   = PW'(MAX_V);
  localparam logic signed [PW-1:0]    MIN_P   = PW'(MIN_V);
  localparam logic signed [PW-1:0]    ROUND_P = PW'(1) << (FRAC - 1);
  localparam logic signed [WIDTH-1:0] COEFF   = WIDTH'(H_COEFF);

  function automatic logic signed [WIDTH-1:0] satNeg(input logic signed [WIDTH-1:0] x);
    if (x == MIN_V) return MAX_V;
    return -x;
  endfunction

  // Sum is WIDTH+1 bits wide, so the product never overflows PW bits.
  function automatic logic signed [WIDTH-1:0] hScale(input logic signed [WIDTH:0] s);
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] shifted;
    prod    = PW'(s) * PW'(COEFF);
    shifted = (prod + ROUND_P) >>> FRAC;
    if (shifted > MAX_P) return MAX_V;
    if (shifted < MIN_P) return MIN_V;
    return shifted[WIDTH-1:0];
  endfunction

  logic signed [WIDTH:0] sumR;
  logic signed [WIDTH:0] sumI;
  logic signed [WIDTH:0] diffR;
  logic signed [WIDTH:0] diffI;

  always_comb begin
    sumR  = (WIDTH+1)'(aR_i) + (WIDTH+1)'(bR_i);
    sumI  = (WIDTH+1)'(aI_i) + (WIDTH+1)'(bI_i);
    diffR = (WIDTH+1)'(aR_i) - (WIDTH+1)'(bR_i);
    diffI = (WIDTH+1)'(aI_i) - (WIDTH+1)'(bI_i);
    aR_o  = aR_i;
    aI_o  = aI_i;
    bR_o  = bR_i;
    bI_o  = bI_i;
    case (op_i)
      OP_X: begin
        aR_o = bR_i;
        aI_o = bI_i;
        bR_o = aR_i;
        bI_o = aI_i;
      end
      OP_Z: begin
        bR_o = satNeg(bR_i);
        bI_o = satNeg(bI_i);
      end
      OP_H: begin
        aR_o = hScale(sumR);
        aI_o = hScale(sumI);
        bR_o = hScale(diffR);
        bI_o = hScale(diffI);
      end
      OP_S: begin
        bR_o = satNeg(bI_i);
        bI_o = bR_i;
      end
      default: begin
        aR_o = aR_i;
      end
    endcase
  end

endmodule

// File: rtl/gate_engine.sv
// Applies one single-qubit gate across the whole state vector, one amplitude
// pair per three cycles (read, write a', write b').
module gate_engine
  import qc_pkg::*;
#(
  parameter int N_QUBITS = 4,
  parameter int WIDTH    = 16,
  parameter int FRAC     = FRAC_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  gate_engine_if.slave bus,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam int                  DEPTH  = 2 ** N_QUBITS;
  localparam int                  TW     = targetWidth(N_QUBITS);
  localparam logic [N_QUBITS-1:0] LAST_K = N_QUBITS'(DEPTH / 2 - 1);
  localparam logic [TW-1:0]       NQ_T   = TW'(N_QUBITS);

  function automatic logic [N_QUBITS-1:0] bitOf(input logic [TW-1:0] t);
    return N_QUBITS'(1) << t;
  endfunction

  // Pair index k with a zero spliced in at the target bit position.
  function automatic logic [N_QUBITS-1:0] insertZero(input logic [N_QUBITS-1:0] kk,
                                                     input logic [TW-1:0]       t);
    logic [N_QUBITS-1:0] lowMask;
    logic [N_QUBITS-1:0] high;
    lowMask = bitOf(t) - N_QUBITS'(1);
    high    = (kk >> t) << t;
    return (high << 1) | (kk & lowMask);
  endfunction

  state_t                     state_q;
  logic        [N_QUBITS-1:0] k_q;
  gate_op_t                   op_q;
  logic        [TW-1:0]       target_q;
  logic                       ready_q;
  logic                       busy_q;
  logic                       done_q;
  logic                       err_q;
  logic                       we_q;
  logic        [N_QUBITS-1:0] addrA_q;
  logic        [N_QUBITS-1:0] addrB_q;
  logic signed [WIDTH-1:0]    dinR_q;
  logic signed [WIDTH-1:0]    dinI_q;
  logic signed [WIDTH-1:0]    resBR_q;
  logic signed [WIDTH-1:0]    resBI_q;

  logic        [N_QUBITS-1:0] kNext_d;
  logic        [N_QUBITS-1:0] i0Next_d;
  logic        [N_QUBITS-1:0] i1Next_d;

  logic signed [WIDTH-1:0]    bfAR;
  logic signed [WIDTH-1:0]    bfAI;
  logic signed [WIDTH-1:0]    bfBR;
  logic signed [WIDTH-1:0]    bfBI;

  always_comb begin
    kNext_d  = k_q + N_QUBITS'(1);
    i0Next_d = insertZero(kNext_d, target_q);
    i1Next_d = i0Next_d | bitOf(target_q);
  end

  cplx_butterfly #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_butterfly (
    .aR_i (bus.mem_dout_a_r),
    .aI_i (bus.mem_dout_a_i),
    .bR_i (bus.mem_dout_b_r),
    .bI_i (bus.mem_dout_b_i),
    .op_i (op_q),
    .aR_o (bfAR),
    .aI_o (bfAI),
    .bR_o (bfBR),
    .bI_o (bfBI)
  );

  // Addresses for the next RD are set up on the edge that enters RD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      k_q      <= '0;
      op_q     <= OP_X;
      target_q <= '0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      we_q     <= 1'b0;
      addrA_q  <= '0;
      addrB_q  <= '0;
      dinR_q   <= '0;
      dinI_q   <= '0;
      resBR_q  <= '0;
      resBI_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.gate_valid && ready_q) begin
            op_q     <= bus.gate_op;
            target_q <= bus.gate_target;
            k_q      <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
            if (bus.gate_target < NQ_T) begin
              state_q <= RD;
              addrA_q <= '0;
              addrB_q <= bitOf(bus.gate_target);
            end else begin
              state_q <= FIN;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end
          end
        end
        RD: begin
          resBR_q <= bfBR;
          resBI_q <= bfBI;
          dinR_q  <= bfAR;
          dinI_q  <= bfAI;
          we_q    <= 1'b1;
          state_q <= WR_A;
        end
        WR_A: begin
          addrA_q <= addrB_q;
          dinR_q  <= resBR_q;
          dinI_q  <= resBI_q;
          state_q <= WR_B;
        end
        WR_B: begin
          we_q <= 1'b0;
          if (k_q < LAST_K) begin
            k_q     <= kNext_d;
            addrA_q <= i0Next_d;
            addrB_q <= i1Next_d;
            state_q <= RD;
          end else begin
            done_q  <= 1'b1;
            state_q <= FIN;
          end
        end
        FIN: begin
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          we_q    <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.gate_ready = ready_q;
  assign bus.mem_we     = we_q;
  assign bus.mem_addr_a = addrA_q;
  assign bus.mem_addr_b = addrB_q;
  assign bus.mem_din_r  = dinR_q;
  assign bus.mem_din_i  = dinI_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;

endmodule

// File: tb/tb_gate_engine.sv
// Self-checking bench for gate_engine: behavioural state-vector model,
// directed scenarios and randomized gates against a modelled state memory.
module tb_gate_engine;
  import qc_pkg::*;

  localparam int NQ       = 4;
  localparam int W        = 16;
  localparam int DEPTH    = 16;
  localparam int GATE_LAT = 3 * DEPTH / 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic busy, done, err;

  int checks   = 0;
  int failures = 0;

  logic signed [W-1:0] memR [DEPTH];
  logic signed [W-1:0] memI [DEPTH];
  logic signed [W-1:0] loadR [DEPTH];
  logic signed [W-1:0] loadI [DEPTH];
  logic loadNow = 1'b0;
  int   weCount = 0;
  int   modelR [DEPTH];
  int   modelI [DEPTH];

  gate_engine_if #(.N_QUBITS(NQ), .WIDTH(W)) bus ();

  gate_engine #(.N_QUBITS(NQ), .WIDTH(W), .FRAC(14)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  assign bus.mem_dout_a_r = memR[bus.mem_addr_a];
  assign bus.mem_dout_a_i = memI[bus.mem_addr_a];
  assign bus.mem_dout_b_r = memR[bus.mem_addr_b];
  assign bus.mem_dout_b_i = memI[bus.mem_addr_b];

  always @(posedge clk) begin
    if (loadNow) begin
      for (int i = 0; i < DEPTH; i++) begin
        memR[i] <= loadR[i];
        memI[i] <= loadI[i];
      end
    end else if (bus.mem_we) begin
      memR[bus.mem_addr_a] <= bus.mem_din_r;
      memI[bus.mem_addr_a] <= bus.mem_din_i;
    end
    if (bus.mem_we) weCount <= weCount + 1;
  end

  function automatic int sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  function automatic int neg(input int v);
    return sat16(-longint'(v));
  endfunction

  function automatic int hMul(input int s);
    return sat16((longint'(s) * 11585 + 8192) >>> 14);
  endfunction

  // Every index with target bit clear pairs with the index that has it set.
  function automatic void applyModel(input int op, input int t);
    int j, ar, ai, br, bi;
    if (t >= NQ) return;
    for (int i = 0; i < DEPTH; i++) begin
      if (((i >> t) & 1) == 0) begin
        j  = i | (1 << t);
        ar = modelR[i]; ai = modelI[i]; br = modelR[j]; bi = modelI[j];
        case (op)
          0: begin modelR[i] = br; modelI[i] = bi; modelR[j] = ar; modelI[j] = ai; end
          1: begin modelR[j] = neg(br); modelI[j] = neg(bi); end
          2: begin
            modelR[i] = hMul(ar + br); modelI[i] = hMul(ai + bi);
            modelR[j] = hMul(ar - br); modelI[j] = hMul(ai - bi);
          end
          default: begin modelR[j] = neg(bi); modelI[j] = br; end
        endcase
      end
    end
  endfunction

  task automatic clearLoad();
    for (int i = 0; i < DEPTH; i++) begin
      loadR[i] = '0;
      loadI[i] = '0;
    end
  endtask

  task automatic randomLoad();
    for (int i = 0; i < DEPTH; i++) begin
      loadR[i] = W'($urandom);
      loadI[i] = W'($urandom);
      if ($urandom_range(0, 7) == 0) loadR[i] = -16'sd32768;
    end
  endtask

  task automatic commitLoad();
    for (int i = 0; i < DEPTH; i++) begin
      modelR[i] = int'(loadR[i]);
      modelI[i] = int'(loadI[i]);
    end
    @(negedge clk);
    loadNow = 1'b1;
    @(posedge clk);
    #1;
    loadNow = 1'b0;
  endtask

  // Issues one request; lat = edges from accept edge until done seen, -1 on timeout.
  task automatic runGate(input int op, input int tgt, input bit hold,
                         output int lat, output bit errSeen);
    logic [1:0] opBits;
    opBits  = op[1:0];
    lat     = -1;
    errSeen = 1'b0;
    @(negedge clk);
    bus.gate_valid  = 1'b1;
    bus.gate_op     = gate_op_t'(opBits);
    bus.gate_target = 3'(tgt);
    for (int w = 0; w < 100 && !bus.gate_ready; w++) @(negedge clk);
    if (!bus.gate_ready) begin
      bus.gate_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (!hold) bus.gate_valid = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (done) begin
        lat     = n;
        errSeen = err;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitIdle();
    for (int n = 0; n < 20 && !bus.gate_ready; n++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.gate_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready: got %b expected 1", bus.gate_ready);
    end
    checks++;
    if ({busy, done, err, bus.mem_we} !== 4'b0000) begin
      failures++; $display("FAIL reset_status: busy/done/err/we got %b expected 0000", {busy, done, err, bus.mem_we});
    end
    checks++;
    if (bus.mem_addr_a !== '0 || bus.mem_addr_b !== '0) begin
      failures++; $display("FAIL reset_addr: got a=%0d b=%0d expected 0 0", bus.mem_addr_a, bus.mem_addr_b);
    end
    checks++;
    if (bus.mem_din_r !== '0 || bus.mem_din_i !== '0) begin
      failures++; $display("FAIL reset_din: got (%0d,%0d) expected (0,0)", bus.mem_din_r, bus.mem_din_i);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_hadamard();
    int lat, weStart;
    bit e;
    clearLoad();
    loadR[0] = 16'sd16384;
    commitLoad();
    weStart = weCount;
    runGate(2, 0, 1'b0, lat, e);
    checks++;
    if (lat !== GATE_LAT) begin
      failures++; $display("FAIL h_latency: got %0d expected %0d", lat, GATE_LAT);
    end
    checks++;
    if (e !== 1'b0) begin
      failures++; $display("FAIL h_err: got %b expected 0", e);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || bus.gate_ready !== 1'b1) begin
      failures++; $display("FAIL h_done_pulse: done=%b ready=%b expected done=0 ready=1", done, bus.gate_ready);
    end
    checks++;
    if (memR[0] !== 16'sd11585 || memI[0] !== 16'sd0 || memR[1] !== 16'sd11585 || memI[1] !== 16'sd0) begin
      failures++; $display("FAIL h_mem: got m0=(%0d,%0d) m1=(%0d,%0d) expected (11585,0) twice",
                           memR[0], memI[0], memR[1], memI[1]);
    end
    checks++;
    if (weCount - weStart !== DEPTH) begin
      failures++; $display("FAIL h_writes: got %0d expected %0d", weCount - weStart, DEPTH);
    end
  endtask

  task automatic test_x();
    int lat, weStart;
    bit e;
    clearLoad();
    loadR[0] = 16'sd16384;
    commitLoad();
    weStart = weCount;
    runGate(0, 2, 1'b0, lat, e);
    checks++;
    if (memR[4] !== 16'sd16384 || memI[4] !== 16'sd0 || memR[0] !== 16'sd0 || memI[0] !== 16'sd0) begin
      failures++; $display("FAIL x_mem: got m4=(%0d,%0d) m0=(%0d,%0d) expected (16384,0) (0,0)",
                           memR[4], memI[4], memR[0], memI[0]);
    end
    checks++;
    if (weCount - weStart !== 16) begin
      failures++; $display("FAIL x_writes: got %0d expected 16", weCount - weStart);
    end
    waitIdle();
  endtask

  task automatic test_z();
    int lat;
    bit e;
    logic signed [W-1:0] keepR, keepI;
    clearLoad();
    loadR[9] = -16'sd32768;
    loadI[9] = 16'sd5;
    loadR[8] = W'($urandom);
    loadI[8] = W'($urandom);
    keepR = loadR[8];
    keepI = loadI[8];
    commitLoad();
    runGate(1, 0, 1'b0, lat, e);
    checks++;
    if (memR[9] !== 16'sd32767 || memI[9] !== -16'sd5) begin
      failures++; $display("FAIL z_mem9: got (%0d,%0d) expected (32767,-5)", memR[9], memI[9]);
    end
    checks++;
    if (memR[8] !== keepR || memI[8] !== keepI) begin
      failures++; $display("FAIL z_mem8: got (%0d,%0d) expected (%0d,%0d)", memR[8], memI[8], keepR, keepI);
    end
    waitIdle();
  endtask

  task automatic test_s_then_h();
    int lat;
    bit e;
    clearLoad();
    loadR[3] = 16'sd100;
    loadI[3] = -16'sd7;
    commitLoad();
    runGate(3, 1, 1'b0, lat, e);
    checks++;
    if (memR[3] !== 16'sd7 || memI[3] !== 16'sd100) begin
      failures++; $display("FAIL s_mem3: got (%0d,%0d) expected (7,100)", memR[3], memI[3]);
    end
    waitIdle();
    clearLoad();
    loadR[1] = 16'sd16384;
    loadR[3] = 16'sd16384;
    commitLoad();
    runGate(2, 1, 1'b0, lat, e);
    checks++;
    if (memR[1] !== 16'sd23170 || memI[1] !== 16'sd0 || memR[3] !== 16'sd0 || memI[3] !== 16'sd0) begin
      failures++; $display("FAIL h_pair: got m1=(%0d,%0d) m3=(%0d,%0d) expected (23170,0) (0,0)",
                           memR[1], memI[1], memR[3], memI[3]);
    end
    waitIdle();
  endtask

  task automatic test_invalid();
    int lat, weStart, tgt, bad;
    bit e;
    for (int it = 0; it < 2; it++) begin
      tgt = (it == 0) ? 4 : int'($urandom_range(5, 7));
      randomLoad();
      commitLoad();
      weStart = weCount;
      runGate(int'($urandom_range(0, 3)), tgt, 1'b0, lat, e);
      checks++;
      if (lat !== 0 || e !== 1'b1) begin
        failures++; $display("FAIL invalid_pulse t=%0d: lat=%0d err=%b expected lat=0 err=1", tgt, lat, e);
      end
      checks++;
      if (weCount - weStart !== 0) begin
        failures++; $display("FAIL invalid_writes t=%0d: got %0d expected 0", tgt, weCount - weStart);
      end
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0 || err !== 1'b0) begin
        failures++; $display("FAIL invalid_one_cycle: done=%b err=%b expected 0 0", done, err);
      end
      bad = 0;
      for (int i = 0; i < DEPTH; i++)
        if (int'(memR[i]) !== modelR[i] || int'(memI[i]) !== modelI[i]) bad++;
      checks++;
      if (bad != 0) begin
        failures++; $display("FAIL invalid_mem: %0d entries changed, expected 0", bad);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat, n2, op, tgt, bad;
    bit e;
    op  = int'($urandom_range(0, 3));
    tgt = int'($urandom_range(0, NQ - 1));
    randomLoad();
    commitLoad();
    applyModel(op, tgt);
    applyModel(op, tgt);
    runGate(op, tgt, 1'b1, lat, e);
    checks++;
    if (lat !== GATE_LAT) begin
      failures++; $display("FAIL b2b_first_latency: got %0d expected %0d", lat, GATE_LAT);
    end
    n2 = -1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) begin
        checks++;
        if (bus.gate_ready !== 1'b1 || busy !== 1'b0) begin
          failures++; $display("FAIL b2b_idle: ready=%b busy=%b expected 1 0", bus.gate_ready, busy);
        end
      end
      if (n == 2) begin
        bus.gate_valid = 1'b0;
        checks++;
        if (bus.gate_ready !== 1'b0 || busy !== 1'b1) begin
          failures++; $display("FAIL b2b_accept: ready=%b busy=%b expected 0 1", bus.gate_ready, busy);
        end
      end
      if (done) begin
        n2 = n;
        break;
      end
    end
    bus.gate_valid = 1'b0;
    checks++;
    if (n2 !== GATE_LAT + 2) begin
      failures++; $display("FAIL b2b_second_done: got %0d edges after first done, expected %0d", n2, GATE_LAT + 2);
    end
    bad = 0;
    for (int i = 0; i < DEPTH; i++)
      if (int'(memR[i]) !== modelR[i] || int'(memI[i]) !== modelI[i]) begin
        if (bad == 0)
          $display("FAIL b2b_mem op=%0d t=%0d idx %0d: got (%0d,%0d) expected (%0d,%0d)",
                   op, tgt, i, memR[i], memI[i], modelR[i], modelI[i]);
        bad++;
      end
    checks++;
    if (bad != 0) failures++;
    waitIdle();
  endtask

  task automatic test_random();
    int lat, weStart, op, tgt, bad, expLat, expWe;
    bit e;
    for (int it = 0; it < 8; it++) begin
      op  = int'($urandom_range(0, 3));
      tgt = int'($urandom_range(0, NQ));
      randomLoad();
      commitLoad();
      applyModel(op, tgt);
      expLat = (tgt < NQ) ? GATE_LAT : 0;
      expWe  = (tgt < NQ) ? DEPTH : 0;
      weStart = weCount;
      runGate(op, tgt, 1'b0, lat, e);
      checks++;
      if (lat !== expLat || e !== (tgt >= NQ)) begin
        failures++; $display("FAIL rand_timing op=%0d t=%0d: lat=%0d err=%b expected lat=%0d err=%b",
                             op, tgt, lat, e, expLat, tgt >= NQ);
      end
      checks++;
      if (weCount - weStart !== expWe) begin
        failures++; $display("FAIL rand_writes op=%0d t=%0d: got %0d expected %0d", op, tgt, weCount - weStart, expWe);
      end
      bad = 0;
      for (int i = 0; i < DEPTH; i++)
        if (int'(memR[i]) !== modelR[i] || int'(memI[i]) !== modelI[i]) begin
          if (bad == 0)
            $display("FAIL rand_mem op=%0d t=%0d idx %0d: got (%0d,%0d) expected (%0d,%0d)",
                     op, tgt, i, memR[i], memI[i], modelR[i], modelI[i]);
          bad++;
        end
      checks++;
      if (bad != 0) failures++;
      waitIdle();
    end
  endtask

  task automatic test_reset_mid();
    int lat, weStart, weSnap, op, tgt, bad;
    bit e, found;
    randomLoad();
    commitLoad();
    weStart = weCount;
    @(negedge clk);
    bus.gate_valid  = 1'b1;
    bus.gate_op     = OP_X;
    bus.gate_target = 3'd0;
    for (int w = 0; w < 20 && !bus.gate_ready; w++) @(negedge clk);
    @(posedge clk);
    #1;
    bus.gate_valid = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (bus.mem_we && (weCount - weStart == 6)) begin
        found = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (!found) begin
      failures++; $display("FAIL mid_reach_pair3: got found=0 expected 1");
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.mem_we !== 1'b0 || bus.gate_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL mid_abort: we=%b ready=%b busy=%b done=%b expected 0 1 0 0",
                           bus.mem_we, bus.gate_ready, busy, done);
    end
    checks++;
    if (bus.mem_addr_a !== '0 || bus.mem_din_r !== '0) begin
      failures++; $display("FAIL mid_abort_bus: addr=%0d din=%0d expected 0 0", bus.mem_addr_a, bus.mem_din_r);
    end
    weSnap = weCount;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (weCount !== weSnap || weSnap - weStart !== 6) begin
      failures++; $display("FAIL mid_no_writes: got %0d writes expected 6", weCount - weStart);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.gate_ready !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL mid_release: ready=%b busy=%b expected 1 0", bus.gate_ready, busy);
    end
    op  = int'($urandom_range(0, 3));
    tgt = int'($urandom_range(0, NQ - 1));
    randomLoad();
    commitLoad();
    applyModel(op, tgt);
    runGate(op, tgt, 1'b0, lat, e);
    checks++;
    if (lat !== GATE_LAT || e !== 1'b0) begin
      failures++; $display("FAIL mid_fresh_timing: lat=%0d err=%b expected %0d 0", lat, e, GATE_LAT);
    end
    bad = 0;
    for (int i = 0; i < DEPTH; i++)
      if (int'(memR[i]) !== modelR[i] || int'(memI[i]) !== modelI[i]) begin
        if (bad == 0)
          $display("FAIL mid_fresh_mem idx %0d: got (%0d,%0d) expected (%0d,%0d)",
                   i, memR[i], memI[i], modelR[i], modelI[i]);
        bad++;
      end
    checks++;
    if (bad != 0) failures++;
    waitIdle();
  endtask

  initial begin
    bus.gate_valid  = 1'b0;
    bus.gate_op     = OP_X;
    bus.gate_target = '0;
    clearLoad();
    test_reset();
    test_hadamard();
    test_x();
    test_z();
    test_s_then_h();
    test_invalid();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
